id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage directly upstream of the 64-bit EX ALU. It registers decoded operands, the immediate and control fields each cycle, then drives the ALU's `data1`, `read2`, `imme`, `ALUSrc` and `ALUcontrol` inputs. It resolves RAW hazards by forwarding from EX/MEM and MEM/WB and by a one-cycle load-use stall. It inserts bubbles on branch flush.

## Interface
- `XLEN`, 64, datapath width.
- `FWD_EN`, 1, 1 = forwarding enabled; 0 = `ex_data1`/`ex_read2` always come from the registered operands.

- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `id_valid` in 1: the ID slot holds a real instruction.
- `id_rs1`, `id_rs2`, `id_rd` in 5 each: register indices.
- `id_read1`, `id_read2` in XLEN: register-file read data.
- `id_imme` in XLEN: sign-extended immediate.
- `id_ALUSrc` in 1, `id_ALUcontrol` in 4: ALU controls.
- `id_MemRead`, `id_MemWrite`, `id_RegWrite`, `id_MemtoReg`, `id_Branch` in 1 each: downstream controls.
- `mem_RegWrite` in 1, `mem_rd` in 5, `mem_result` in XLEN: EX/MEM writeback candidate.
- `wb_RegWrite` in 1, `wb_rd` in 5, `wb_data` in XLEN: MEM/WB writeback (same value written to the register file this cycle).
- `flush` in 1: taken branch; the ID instruction must not enter EX.
- `stall` out 1: holds the PC and IF/ID (combinational).
- `ex_valid` out 1: the EX slot holds a real instruction.
- `ex_data1`, `ex_read2` out XLEN: forwarded operands to the ALU.
- `ex_imme` out XLEN: registered immediate.
- `ex_ALUSrc` out 1, `ex_ALUcontrol` out 4: registered ALU controls.
- `ex_MemRead`, `ex_MemWrite`, `ex_RegWrite`, `ex_MemtoReg`, `ex_Branch` out 1 each: registered controls.
- `ex_rs1`, `ex_rs2`, `ex_rd` out 5 each: registered indices.

## Operation
- **Reset** (`rst_n` low, asynchronous): every registered field clears to 0, so `ex_valid`=0 and all `ex_*` outputs are 0.
  - `stall`=0.
  - `ex_data1`/`ex_read2` = 0, unless a forward hit matches index 0, which is excluded, so they are 0.
- **Capture** on each rising edge, three cases:
  - **Normal** (no flush, no stall): load all `id_*` fields; `ex_valid` <= `id_valid`.
  - **Bubble** (`flush`=1, or `stall`=1): `ex_valid`, `ex_MemRead`, `ex_MemWrite`, `ex_RegWrite`, `ex_Branch`, `ex_MemtoReg`, `ex_ALUSrc` <= 0; `ex_ALUcontrol` <= 4'b0000; indices and data <= 0.
  - **Invalid ID** (`id_valid`=0): treated as a bubble.
- **Write-through at capture:**
  - If `wb_RegWrite` and `wb_rd`!=0 and `wb_rd`==`id_rs1`, capture `wb_data` instead of `id_read1`.
  - Same rule for rs2/`id_read2`.
- **Forwarding** (combinational, `FWD_EN`=1):
  - `ex_data1` = `mem_result` if `mem_RegWrite` & `mem_rd`!=0 & `mem_rd`==`ex_rs1`;
  - else `wb_data` if `wb_RegWrite` & `wb_rd`!=0 & `wb_rd`==`ex_rs1`;
  - else the registered read1.
  - `ex_read2` follows the same rule with `ex_rs2`.
  - EX/MEM wins over MEM/WB.
  - Forwarding is gated by `ex_valid`; a bubble outputs 0.
- **Load-use:**
  - `stall` = `ex_valid` & `ex_MemRead` & `ex_rd`!=0 & `id_valid` & (`ex_rd`==`id_rs1` | `ex_rd`==`id_rs2`).
  - The index compare is unconditional on whether the instruction uses rs2 (conservative, accepted).
- **Simultaneous events:**
  - `flush` and `stall` together: bubble, and `stall` is still driven.
  - Upstream flush logic overrides the hold; the squashed instruction is discarded.
- **Width:** all data paths are XLEN bits with no truncation; indices are 5 bits.

## Timing
- ID-to-EX latency is 1 cycle. Values presented with `id_valid`=1 appear on `ex_*` after the next rising edge.
- `stall` and the forward muxes are combinational within the cycle; there are no internal registers beyond ID/EX.
- A load-use stall lasts exactly 1 cycle: the inserted bubble has `ex_MemRead`=0, so `stall` drops the next cycle. The dependent instruction then enters EX and takes the loaded value via the MEM/WB forward.
- Back-to-back loads to the same rd stall once per dependent consumer only.
- Reset asserted mid-stall or mid-flush clears the registers immediately; the first edge after `rst_n` rises captures normally.

## Test plan
- **Reset:** hold `rst_n`=0, drive `id_*` nonzero → all `ex_*`=0, `stall`=0. Release, then present ADD x3,x1,x2 with read1=5, read2=7 → next cycle `ex_data1`=5, `ex_read2`=7, `ex_ALUcontrol`=4'b0010, `ex_valid`=1.
- **EX/MEM forward:** EX holds rs1=3, registered read1=5; `mem_RegWrite`=1, `mem_rd`=3, `mem_result`=0x0C → `ex_data1`=0x0C. Same cycle, also drive `wb_rd`=3, `wb_data`=0x99 → still 0x0C.
- **x0 never forwarded:** EX rs2=0, `mem_rd`=0, `mem_RegWrite`=1, `mem_result`=0xFF → `ex_read2` = registered value (0).
- **Load-use:** EX holds LD x5 (`ex_MemRead`=1, rd=5); ID holds rs1=5 → `stall`=1 for one cycle. Next EX is a bubble (`ex_valid`=0, `ex_RegWrite`=0). The cycle after, the consumer is in EX with `wb_rd`=5, `wb_data`=0x1234 → `ex_data1`=0x1234.
- **Flush + write-through:** `flush`=1 with a valid ID instruction → next `ex_valid`=0, all controls 0. Then capture with `wb_RegWrite`=1, `wb_rd`=`id_rs2`=4, `wb_data`=0xABCD, `id_read2`=0 → registered read2=0xABCD.
- **Reset mid-stall:** assert `rst_n`=0 asynchronously while `stall`=1 → outputs clear within the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register in front of the 64-bit EX ALU. It captures decoded
// operands, the immediate and controls every cycle. RAW hazards are resolved by
// forwarding from EX/MEM and MEM/WB, and by a one-cycle load-use stall. A
// branch flush or an invalid ID slot inserts a bubble.
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   id_*                               decoded instruction in the ID slot
//   mem_RegWrite/mem_rd/mem_result     EX/MEM writeback candidate
//   wb_RegWrite/wb_rd/wb_data          MEM/WB writeback (also hits the RF now)
//   flush                              taken branch, squash the ID instruction
//   stall                              combinational hold for PC and IF/ID
//   ex_data1/ex_read2                  forwarded ALU operands (combinational)
//   ex_*                               registered EX-slot fields
// ----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned FWD_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [XLEN-1:0] id_read1,
  input  logic [XLEN-1:0] id_read2,
  input  logic [XLEN-1:0] id_imme,
  input  logic            id_ALUSrc,
  input  logic [3:0]      id_ALUcontrol,
  input  logic            id_MemRead,
  input  logic            id_MemWrite,
  input  logic            id_RegWrite,
  input  logic            id_MemtoReg,
  input  logic            id_Branch,
  input  logic            mem_RegWrite,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_RegWrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_data1,
  output logic [XLEN-1:0] ex_read2,
  output logic [XLEN-1:0] ex_imme,
  output logic            ex_ALUSrc,
  output logic [3:0]      ex_ALUcontrol,
  output logic            ex_MemRead,
  output logic            ex_MemWrite,
  output logic            ex_RegWrite,
  output logic            ex_MemtoReg,
  output logic            ex_Branch,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd
);

  localparam logic FwdOn = (FWD_EN != 0);

  logic            valid_q,    valid_d;
  logic [4:0]      rs1_q,      rs1_d;
  logic [4:0]      rs2_q,      rs2_d;
  logic [4:0]      rd_q,       rd_d;
  logic [XLEN-1:0] read1_q,    read1_d;
  logic [XLEN-1:0] read2_q,    read2_d;
  logic [XLEN-1:0] imme_q,     imme_d;
  logic            alusrc_q,   alusrc_d;
  logic [3:0]      aluctl_q,   aluctl_d;
  logic            memread_q,  memread_d;
  logic            memwrite_q, memwrite_d;
  logic            regwrite_q, regwrite_d;
  logic            memtoreg_q, memtoreg_d;
  logic            branch_q,   branch_d;

  logic capture;
  logic wt1, wt2;
  logic mem_hit1, mem_hit2, wb_hit1, wb_hit2;

  // Load-use hazard: rs2 is compared even when unused (conservative).
  assign stall = valid_q & memread_q & (rd_q != 5'd0) & id_valid &
                 ((rd_q == id_rs1) | (rd_q == id_rs2));

  assign capture = id_valid & ~flush & ~stall;

  // Register file write in this same cycle would be missed by id_read*.
  assign wt1 = wb_RegWrite & (wb_rd != 5'd0) & (wb_rd == id_rs1);
  assign wt2 = wb_RegWrite & (wb_rd != 5'd0) & (wb_rd == id_rs2);

  // Next-state: normal capture, otherwise an all-zero bubble.
  always_comb begin
    valid_d    = 1'b0;
    rs1_d      = '0;
    rs2_d      = '0;
    rd_d       = '0;
    read1_d    = '0;
    read2_d    = '0;
    imme_d     = '0;
    alusrc_d   = 1'b0;
    aluctl_d   = 4'b0000;
    memread_d  = 1'b0;
    memwrite_d = 1'b0;
    regwrite_d = 1'b0;
    memtoreg_d = 1'b0;
    branch_d   = 1'b0;
    if (capture) begin
      valid_d    = 1'b1;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
      read1_d    = wt1 ? wb_data : id_read1;
      read2_d    = wt2 ? wb_data : id_read2;
      imme_d     = id_imme;
      alusrc_d   = id_ALUSrc;
      aluctl_d   = id_ALUcontrol;
      memread_d  = id_MemRead;
      memwrite_d = id_MemWrite;
      regwrite_d = id_RegWrite;
      memtoreg_d = id_MemtoReg;
      branch_d   = id_Branch;
    end
  end

  // ID/EX register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      read1_q    <= '0;
      read2_q    <= '0;
      imme_q     <= '0;
      alusrc_q   <= 1'b0;
      aluctl_q   <= 4'b0000;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      branch_q   <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      read1_q    <= read1_d;
      read2_q    <= read2_d;
      imme_q     <= imme_d;
      alusrc_q   <= alusrc_d;
      aluctl_q   <= aluctl_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      branch_q   <= branch_d;
    end
  end

  // x0 is never a forwarding source.
  assign mem_hit1 = FwdOn & mem_RegWrite & (mem_rd != 5'd0) & (mem_rd == rs1_q);
  assign mem_hit2 = FwdOn & mem_RegWrite & (mem_rd != 5'd0) & (mem_rd == rs2_q);
  assign wb_hit1  = FwdOn & wb_RegWrite  & (wb_rd  != 5'd0) & (wb_rd  == rs1_q);
  assign wb_hit2  = FwdOn & wb_RegWrite  & (wb_rd  != 5'd0) & (wb_rd  == rs2_q);

  // Operand muxes: EX/MEM is younger than MEM/WB, so it takes priority.
  always_comb begin
    ex_data1 = '0;
    ex_read2 = '0;
    if (valid_q) begin
      if (mem_hit1)     ex_data1 = mem_result;
      else if (wb_hit1) ex_data1 = wb_data;
      else              ex_data1 = read1_q;
      if (mem_hit2)     ex_read2 = mem_result;
      else if (wb_hit2) ex_read2 = wb_data;
      else              ex_read2 = read2_q;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_imme       = imme_q;
  assign ex_ALUSrc     = alusrc_q;
  assign ex_ALUcontrol = aluctl_q;
  assign ex_MemRead    = memread_q;
  assign ex_MemWrite   = memwrite_q;
  assign ex_RegWrite   = regwrite_q;
  assign ex_MemtoReg   = memtoreg_q;
  assign ex_Branch     = branch_q;
  assign ex_rs1        = rs1_q;
  assign ex_rs2        = rs2_q;
  assign ex_rd         = rd_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed scenarios followed by randomized traffic, checked against a
// behavioural model of the EX slot held in the bench.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int unsigned XLEN = 64;

  logic            clk;
  logic            rst_n;
  logic            id_valid;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic [XLEN-1:0] id_read1, id_read2, id_imme;
  logic            id_ALUSrc;
  logic [3:0]      id_ALUcontrol;
  logic            id_MemRead, id_MemWrite, id_RegWrite, id_MemtoReg, id_Branch;
  logic            mem_RegWrite;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_result;
  logic            wb_RegWrite;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            flush;
  logic            stall;
  logic            ex_valid;
  logic [XLEN-1:0] ex_data1, ex_read2, ex_imme;
  logic            ex_ALUSrc;
  logic [3:0]      ex_ALUcontrol;
  logic            ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg, ex_Branch;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;

  int n_cmp;
  int n_mis;

  id_ex_stage #(.XLEN(XLEN), .FWD_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_read1(id_read1), .id_read2(id_read2), .id_imme(id_imme),
    .id_ALUSrc(id_ALUSrc), .id_ALUcontrol(id_ALUcontrol),
    .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .id_RegWrite(id_RegWrite), .id_MemtoReg(id_MemtoReg), .id_Branch(id_Branch),
    .mem_RegWrite(mem_RegWrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_data1(ex_data1), .ex_read2(ex_read2),
    .ex_imme(ex_imme), .ex_ALUSrc(ex_ALUSrc), .ex_ALUcontrol(ex_ALUcontrol),
    .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .ex_RegWrite(ex_RegWrite), .ex_MemtoReg(ex_MemtoReg), .ex_Branch(ex_Branch),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of what instruction currently sits in EX.
  typedef struct packed {
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic [63:0] r1, r2, imm;
    logic       src;
    logic [3:0] ctl;
    logic       mr, mw, rw, m2r, br;
  } ex_t;

  ex_t m;

  function automatic logic exp_stall();
    return m.v && m.mr && (m.rd != 5'd0) && id_valid &&
           ((m.rd == id_rs1) || (m.rd == id_rs2));
  endfunction

  // Newest in-flight producer of register rs, else the value captured in EX.
  function automatic logic [63:0] exp_fwd(input logic [4:0] rs, input logic [63:0] r);
    if (!m.v) return 64'd0;
    if (rs == 5'd0) return r;
    if (mem_RegWrite && mem_rd == rs) return mem_result;
    if (wb_RegWrite && wb_rd == rs) return wb_data;
    return r;
  endfunction

  function automatic ex_t next_ex();
    ex_t n;
    n = '0;
    if (id_valid && !flush && !exp_stall()) begin
      n.v   = 1'b1;
      n.rs1 = id_rs1;  n.rs2 = id_rs2;  n.rd = id_rd;
      n.r1  = (wb_RegWrite && wb_rd != 5'd0 && wb_rd == id_rs1) ? wb_data : id_read1;
      n.r2  = (wb_RegWrite && wb_rd != 5'd0 && wb_rd == id_rs2) ? wb_data : id_read2;
      n.imm = id_imme;
      n.src = id_ALUSrc;  n.ctl = id_ALUcontrol;
      n.mr  = id_MemRead; n.mw = id_MemWrite; n.rw = id_RegWrite;
      n.m2r = id_MemtoReg; n.br = id_Branch;
    end
    return n;
  endfunction

  function automatic logic [63:0] obs_ctl();
    return 64'({ex_valid, ex_rs1, ex_rs2, ex_rd, ex_ALUSrc, ex_ALUcontrol,
                ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg, ex_Branch});
  endfunction

  function automatic logic [63:0] exp_ctl();
    return 64'({m.v, m.rs1, m.rs2, m.rd, m.src, m.ctl, m.mr, m.mw, m.rw, m.m2r, m.br});
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".stall"}, 64'(stall), 64'(exp_stall()));
    chk({tag, ".data1"}, ex_data1, exp_fwd(m.rs1, m.r1));
    chk({tag, ".read2"}, ex_read2, exp_fwd(m.rs2, m.r2));
    chk({tag, ".ctl"},   obs_ctl(), exp_ctl());
    chk({tag, ".imme"},  ex_imme, m.imm);
  endtask

  task automatic tick();
    ex_t n;
    n = rst_n ? next_ex() : '0;
    @(posedge clk);
    m = n;
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_read1 = '0; id_read2 = '0; id_imme = '0;
    id_ALUSrc = 1'b0; id_ALUcontrol = 4'b0000;
    id_MemRead = 1'b0; id_MemWrite = 1'b0; id_RegWrite = 1'b0;
    id_MemtoReg = 1'b0; id_Branch = 1'b0;
    mem_RegWrite = 1'b0; mem_rd = '0; mem_result = '0;
    wb_RegWrite = 1'b0; wb_rd = '0; wb_data = '0;
    flush = 1'b0;
  endtask

  task automatic put_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [63:0] r1,
                           input logic [63:0] r2, input logic [3:0] ctl,
                           input logic ld);
    id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_read1 = r1; id_read2 = r2; id_imme = 64'h10;
    id_ALUSrc = ld; id_ALUcontrol = ctl;
    id_MemRead = ld; id_MemWrite = 1'b0; id_RegWrite = 1'b1;
    id_MemtoReg = ld; id_Branch = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    m = '0;
    idle();
    rst_n = 1'b0;

    // Reset with busy ID inputs: everything stays zero across an edge.
    put_instr(5'd1, 5'd2, 5'd3, 64'h55, 64'h66, 4'b0110, 1'b1);
    id_Branch = 1'b1; id_MemWrite = 1'b1;
    #2;
    chk("rst.ctl", obs_ctl(), 64'd0);
    tick();
    chk("rst.ctl_after_edge", obs_ctl(), 64'd0);
    chk("rst.stall", 64'(stall), 64'd0);
    chk("rst.data1", ex_data1, 64'd0);
    chk("rst.read2", ex_read2, 64'd0);
    chk("rst.imme", ex_imme, 64'd0);

    // ADD x3,x1,x2 just after release.
    rst_n = 1'b1;
    idle();
    put_instr(5'd1, 5'd2, 5'd3, 64'd5, 64'd7, 4'b0010, 1'b0);
    #1;
    tick();
    chk("add.data1", ex_data1, 64'd5);
    chk("add.read2", ex_read2, 64'd7);
    chk("add.aluctl", 64'(ex_ALUcontrol), 64'h2);
    chk("add.valid", 64'(ex_valid), 64'd1);
    check_all("add");

    // EX holds rs1=3 (read1=5), rs2=0.
    put_instr(5'd3, 5'd0, 5'd6, 64'd5, 64'd0, 4'b0010, 1'b0);
    #1;
    tick();
    id_valid = 1'b0;
    mem_RegWrite = 1'b1; mem_rd = 5'd3; mem_result = 64'h0C;
    #1;
    chk("fwd.mem", ex_data1, 64'h0C);
    wb_RegWrite = 1'b1; wb_rd = 5'd3; wb_data = 64'h99;
    #1;
    chk("fwd.mem_over_wb", ex_data1, 64'h0C);
    mem_RegWrite = 1'b0;
    #1;
    chk("fwd.wb", ex_data1, 64'h99);
    wb_RegWrite = 1'b0; mem_RegWrite = 1'b1; mem_rd = 5'd0; mem_result = 64'hFF;
    #1;
    chk("fwd.x0_read2", ex_read2, 64'd0);
    chk("fwd.x0_data1", ex_data1, 64'd5);
    idle();

    // Load-use: LD x5 then consumer of x5.
    put_instr(5'd1, 5'd0, 5'd5, 64'h100, 64'd0, 4'b0010, 1'b1);
    #1;
    tick();
    put_instr(5'd5, 5'd2, 5'd7, 64'd0, 64'd3, 4'b0010, 1'b0);
    #1;
    chk("lu.stall", 64'(stall), 64'd1);
    tick();
    chk("lu.bubble_valid", 64'(ex_valid), 64'd0);
    chk("lu.bubble_rw", 64'(ex_RegWrite), 64'd0);
    chk("lu.stall_drop", 64'(stall), 64'd0);
    tick();
    id_valid = 1'b0;
    wb_RegWrite = 1'b1; wb_rd = 5'd5; wb_data = 64'h1234;
    #1;
    chk("lu.fwd_wb", ex_data1, 64'h1234);
    chk("lu.valid", 64'(ex_valid), 64'd1);
    check_all("lu");
    idle();

    // Flush squashes a valid instruction.
    put_instr(5'd8, 5'd9, 5'd10, 64'h1, 64'h2, 4'b1111, 1'b1);
    id_MemWrite = 1'b1; id_Branch = 1'b1; flush = 1'b1;
    #1;
    tick();
    chk("flush.ctl", obs_ctl(), 64'd0);
    chk("flush.imme", ex_imme, 64'd0);
    idle();

    // Write-through of MEM/WB into captured read2.
    put_instr(5'd9, 5'd4, 5'd11, 64'h1, 64'd0, 4'b0010, 1'b0);
    wb_RegWrite = 1'b1; wb_rd = 5'd4; wb_data = 64'hABCD;
    #1;
    tick();
    wb_RegWrite = 1'b0; id_valid = 1'b0;
    #1;
    chk("wt.read2", ex_read2, 64'hABCD);
    chk("wt.data1", ex_data1, 64'h1);
    idle();

    // Async reset in the middle of a stall cycle.
    put_instr(5'd1, 5'd0, 5'd5, 64'h100, 64'd0, 4'b0010, 1'b1);
    #1;
    tick();
    put_instr(5'd2, 5'd5, 5'd7, 64'd4, 64'd0, 4'b0010, 1'b0);
    #1;
    chk("rststall.stall_before", 64'(stall), 64'd1);
    rst_n = 1'b0;
    #1;
    m = '0;
    chk("rststall.stall", 64'(stall), 64'd0);
    chk("rststall.ctl", obs_ctl(), 64'd0);
    chk("rststall.data1", ex_data1, 64'd0);
    rst_n = 1'b1;
    #1;
    tick();
    chk("rststall.capture_valid", 64'(ex_valid), 64'd1);
    chk("rststall.capture_rs2", 64'(ex_rs2), 64'd5);
    check_all("rststall");
    idle();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      id_valid      = ($urandom_range(0, 3) != 0);
      id_rs1        = 5'($urandom_range(0, 7));
      id_rs2        = 5'($urandom_range(0, 7));
      id_rd         = 5'($urandom_range(0, 7));
      id_read1      = {$urandom, $urandom};
      id_read2      = {$urandom, $urandom};
      id_imme       = {$urandom, $urandom};
      id_ALUSrc     = 1'($urandom);
      id_ALUcontrol = 4'($urandom);
      id_MemRead    = ($urandom_range(0, 2) == 0);
      id_MemWrite   = 1'($urandom);
      id_RegWrite   = 1'($urandom);
      id_MemtoReg   = 1'($urandom);
      id_Branch     = 1'($urandom);
      mem_RegWrite  = 1'($urandom);
      mem_rd        = 5'($urandom_range(0, 7));
      mem_result    = {$urandom, $urandom};
      wb_RegWrite   = 1'($urandom);
      wb_rd         = 5'($urandom_range(0, 7));
      wb_data       = {$urandom, $urandom};
      flush         = ($urandom_range(0, 7) == 0);
      #1;
      check_all("rand");
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
